// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    RK_CONDBR = 2'd0,
    RK_B      = 2'd1,
    RK_BR     = 2'd2,
    RK_RSVD   = 2'd3
  } redirect_kind_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if_fifo.sv
// Small instruction queue of {pc, instr} entries with synchronous flush.
// Head outputs read straight from storage registers and read zero when empty.
module instr_fifo #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 64,
  parameter int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W   = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               full, empty, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !flush_i && !full;
  assign do_pop  = pop_i && !flush_i && !empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PTR_W'(1);
      if (do_pop)  head_q <= head_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      instr_q[tail_q] <= push_instr_i;
      pc_q[tail_q]    <= push_pc_i;
    end
  end

  assign valid_o      = !empty;
  assign head_instr_o = empty ? '0 : instr_q[head_q];
  assign head_pc_o    = empty ? '0 : pc_q[head_q];
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_if.sv
// Instruction-fetch stage: owns the PC, keeps one fetch in flight, buffers
// responses for decode and handles branch redirects with squash of stale data.
module fetch_if import fetch_pkg::*; #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic [63:0] if_blt,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [63:0] redirect_pc,
  input  logic [25:0] redirect_imm,
  input  logic [63:0] redirect_reg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               redirect_take;
  logic               imem_accept;
  logic [ADDR_W-1:0]  target;
  logic               fifo_push, fifo_pop, fifo_valid;
  logic [CNT_W-1:0]   fifo_count;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;

  // Branch offsets are word counts; shift by two and add with 64-bit wrap.
  function automatic logic [ADDR_W-1:0] branch_target(
    input redirect_kind_t    kind,
    input logic [ADDR_W-1:0] pc,
    input logic [25:0]       imm,
    input logic [ADDR_W-1:0] reg_tgt
  );
    logic signed [ADDR_W-1:0] off;
    logic [ADDR_W-1:0]        tgt;
    off = '0;
    tgt = reg_tgt & ~ADDR_W'(3);
    case (kind)
      RK_CONDBR: begin
        off = {{(ADDR_W-21){imm[18]}}, imm[18:0], 2'b00};
        tgt = pc + $unsigned(off);
      end
      RK_B: begin
        off = {{(ADDR_W-28){imm[25]}}, imm, 2'b00};
        tgt = pc + $unsigned(off);
      end
      default: ;
    endcase
    return tgt;
  endfunction

  assign redirect_take = redirect_valid && (redirect_kind_t'(redirect_kind) != RK_RSVD);
  assign target        = branch_target(redirect_kind_t'(redirect_kind), redirect_pc,
                                       redirect_imm, redirect_reg);

  // Issue only with a free slot reserved for the response.
  assign imem_req    = reset_n && (state_q == ST_RUN) && (fifo_count < CNT_W'(DEPTH))
                       && !redirect_take;
  assign imem_addr   = pc_q;
  assign imem_accept = imem_req && imem_ready;

  assign fifo_push = (state_q == ST_WAIT) && imem_rvalid && !redirect_take;
  assign fifo_pop  = if_valid && if_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_take) begin
      pc_d    = target;
      state_d = ((state_q == ST_RUN) || imem_rvalid) ? ST_RUN : ST_WAIT_DROP;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (imem_accept) begin
            pc_d     = pc_q + ADDR_W'(4);
            req_pc_d = pc_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT:      if (imem_rvalid) state_d = ST_RUN;
        ST_WAIT_DROP: if (imem_rvalid) state_d = ST_RUN;
        default:      state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  instr_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .flush_i      (redirect_take),
    .push_i       (fifo_push),
    .push_instr_i (imem_rdata),
    .push_pc_i    (req_pc_q),
    .pop_i        (fifo_pop),
    .valid_o      (fifo_valid),
    .head_instr_o (head_instr),
    .head_pc_o    (head_pc),
    .count_o      (fifo_count)
  );

  assign if_valid = fifo_valid;
  assign if_instr = head_instr;
  assign if_pc    = head_pc;
  assign if_blt   = fifo_valid ? head_pc + ADDR_W'(4) : '0;

endmodule
